// File: rtl/apb2wb_pkg.sv
// Shared definitions for the APB-to-Wishbone bridge.
//   state_t    : bridge FSM states
//   DATA_WIDTH : Wishbone/APB data bus width
//   SEL_WIDTH  : byte select / strobe width
//   cnt_width  : watchdog counter width for a given TIMEOUT (minimum 1)
package apb2wb_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned SEL_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE,
    STB,
    WAIT,
    DONE
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned timeout);
    int unsigned w;
    w = int'($clog2(timeout + 1));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb2wb_bridge_if.sv
// Bus bundle between the host APB interconnect and a pipelined Wishbone
// slave, as seen by apb2wb_bridge.
//   slave  : bridge side (APB completer, WB initiator)
//   master : environment side (APB requester, WB responder)
// Signals keep their historical _i/_o names relative to the bridge.
interface apb2wb_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  import apb2wb_pkg::*;

  // APB
  logic                  psel_i;
  logic                  penable_i;
  logic                  pwrite_i;
  logic [ADDR_WIDTH-1:0] paddr_i;
  logic [DATA_WIDTH-1:0] pwdata_i;
  logic [SEL_WIDTH-1:0]  pstrb_i;
  logic                  pready_o;
  logic [DATA_WIDTH-1:0] prdata_o;
  logic                  pslverr_o;
  // Wishbone
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [SEL_WIDTH-1:0]  wb_sel_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic                  wb_ack_i;
  logic                  wb_err_i;
  logic                  wb_rty_i;
  logic                  wb_stall_i;
  logic [DATA_WIDTH-1:0] wb_dat_i;

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
    output pready_o, prdata_o, pslverr_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
  );

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
    input  pready_o, prdata_o, pslverr_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
  );

endinterface

// File: rtl/apb2wb_bridge.sv
// APB3/APB4 to pipelined Wishbone bridge. Each APB transfer produces exactly
// one Wishbone strobe; the response (read data / error) is returned on APB.
// A saturating watchdog ends a cycle the slave never terminates.
// Ports:
//   clk_i   : clock shared by both buses
//   rst_n_i : asynchronous active-low reset
//   bus     : apb2wb_bridge_if.slave (APB completer + WB initiator)
// Parameters:
//   ADDR_WIDTH : byte address width, passed through unchanged
//   TIMEOUT    : cycles from first strobe to forced termination, 0 = off
module apb2wb_bridge
  import apb2wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  apb2wb_bridge_if.slave   bus
);

  localparam int unsigned     CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic                  r_we;
  logic                  r_cyc;
  logic                  r_stb;
  logic                  r_pready;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_slverr;

  logic                  w_acc_term;
  logic                  w_timeout;
  logic                  w_finish;
  logic                  w_fail;
  logic                  w_slverr_nxt;
  logic [DATA_WIDTH-1:0] w_prdata_nxt;

  // A termination only counts once the strobe has been accepted (no stall);
  // err/rty outrank ack, so any of them forces slverr.
  always_comb begin
    w_fail       = bus.wb_err_i | bus.wb_rty_i;
    w_acc_term   = ((r_state == WAIT) || (r_state == STB && !bus.wb_stall_i)) &&
                   (bus.wb_ack_i | w_fail);
    w_timeout    = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
    w_finish     = ((r_state == STB) || (r_state == WAIT)) && (w_acc_term || w_timeout);
    w_slverr_nxt = w_acc_term ? w_fail : 1'b1;
    w_prdata_nxt = (w_acc_term && !w_fail && !r_we) ? bus.wb_dat_i : '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_sel    <= '0;
      r_we     <= 1'b0;
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
      r_pready <= 1'b0;
      r_prdata <= '0;
      r_slverr <= 1'b0;
    end else if (w_finish) begin
      r_state  <= DONE;
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
      r_pready <= 1'b1;
      r_prdata <= w_prdata_nxt;
      r_slverr <= w_slverr_nxt;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.psel_i) begin
            r_adr   <= bus.paddr_i;
            r_dat   <= bus.pwdata_i;
            r_we    <= bus.pwrite_i;
            r_sel   <= bus.pwrite_i ? bus.pstrb_i : '1;
            r_cnt   <= '0;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_state <= STB;
          end
        end
        STB: begin
          r_cnt <= (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
          if (!bus.wb_stall_i) begin
            r_stb   <= 1'b0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_cnt <= (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
        end
        DONE: begin
          // Complete on access phase, or drop the response if psel went away.
          if (!bus.psel_i || bus.penable_i) begin
            r_pready <= 1'b0;
            r_prdata <= '0;
            r_slverr <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.wb_cyc_o  = r_cyc;
  assign bus.wb_stb_o  = r_stb;
  assign bus.wb_we_o   = r_we;
  assign bus.wb_adr_o  = r_adr;
  assign bus.wb_sel_o  = r_sel;
  assign bus.wb_dat_o  = r_dat;
  assign bus.pready_o  = r_pready;
  assign bus.prdata_o  = r_prdata;
  assign bus.pslverr_o = r_slverr;

endmodule

// File: tb/tb_apb2wb_bridge.sv
// Directed testbench for apb2wb_bridge: default watchdog instance plus
// TIMEOUT=8 and TIMEOUT=0 instances.
module tb_apb2wb_bridge;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   pulses   = 0;
  int   stb_cyc  = 0;
  logic stb_q    = 1'b0;
  int   p0, c0, n, bad;

  always #5 clk = ~clk;

  apb2wb_bridge_if #(.ADDR_WIDTH(32)) bus  ();
  apb2wb_bridge_if #(.ADDR_WIDTH(32)) bus8 ();
  apb2wb_bridge_if #(.ADDR_WIDTH(32)) bus0 ();

  apb2wb_bridge #(.ADDR_WIDTH(32), .TIMEOUT(255)) dut  (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));
  apb2wb_bridge #(.ADDR_WIDTH(32), .TIMEOUT(8))   dut8 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus8));
  apb2wb_bridge #(.ADDR_WIDTH(32), .TIMEOUT(0))   dut0 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus0));

  // Strobe activity on the main instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.wb_stb_o) stb_cyc++;
    if (bus.wb_stb_o && !stb_q) pulses++;
    stb_q = bus.wb_stb_o;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Setup phase in the current cycle; returns in the first STB cycle with penable high.
  task automatic apb_start(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    bus.psel_i    = 1'b1;
    bus.penable_i = 1'b0;
    bus.pwrite_i  = w;
    bus.paddr_i   = a;
    bus.pwdata_i  = d;
    bus.pstrb_i   = s;
    tick();
    bus.penable_i = 1'b1;
  endtask

  task automatic wb_resp(input logic a, input logic e, input logic r, input logic [31:0] d);
    bus.wb_ack_i = a; bus.wb_err_i = e; bus.wb_rty_i = r; bus.wb_dat_i = d;
    tick();
    bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0; bus.wb_dat_i = '0;
  endtask

  // From DONE with access phase held: complete, then release APB in IDLE.
  task automatic apb_end;
    tick();
    bus.psel_i = 1'b0; bus.penable_i = 1'b0;
  endtask

  initial begin
    {bus.psel_i, bus.penable_i, bus.pwrite_i, bus.paddr_i, bus.pwdata_i, bus.pstrb_i} = '0;
    {bus.wb_ack_i, bus.wb_err_i, bus.wb_rty_i, bus.wb_stall_i, bus.wb_dat_i} = '0;
    {bus8.psel_i, bus8.penable_i, bus8.pwrite_i, bus8.paddr_i, bus8.pwdata_i, bus8.pstrb_i} = '0;
    {bus8.wb_ack_i, bus8.wb_err_i, bus8.wb_rty_i, bus8.wb_stall_i, bus8.wb_dat_i} = '0;
    {bus0.psel_i, bus0.penable_i, bus0.pwrite_i, bus0.paddr_i, bus0.pwdata_i, bus0.pstrb_i} = '0;
    {bus0.wb_ack_i, bus0.wb_err_i, bus0.wb_rty_i, bus0.wb_stall_i, bus0.wb_dat_i} = '0;
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_cyc",    bus.wb_cyc_o,  0);
    chk("rst_stb",    bus.wb_stb_o,  0);
    chk("rst_we",     bus.wb_we_o,   0);
    chk("rst_adr",    bus.wb_adr_o,  0);
    chk("rst_sel",    bus.wb_sel_o,  0);
    chk("rst_dat",    bus.wb_dat_o,  0);
    chk("rst_pready", bus.pready_o,  0);
    chk("rst_prdata", bus.prdata_o,  0);
    chk("rst_slverr", bus.pslverr_o, 0);
    rst_n = 1'b1;
    tick();

    // Zero-stall read, ack one cycle after the strobe.
    p0 = pulses; c0 = stb_cyc;
    apb_start(1'b0, 32'h10, 32'h0, 4'h0);
    chk("rd_stb",    bus.wb_stb_o, 1);
    chk("rd_cyc",    bus.wb_cyc_o, 1);
    chk("rd_we",     bus.wb_we_o,  0);
    chk("rd_sel",    bus.wb_sel_o, 4'hF);
    chk("rd_adr",    bus.wb_adr_o, 32'h10);
    chk("rd_pready_t1", bus.pready_o, 0);
    tick();
    chk("rd_wait_stb", bus.wb_stb_o, 0);
    chk("rd_wait_cyc", bus.wb_cyc_o, 1);
    wb_resp(1'b1, 1'b0, 1'b0, 32'h0000_0712);
    chk("rd_pready_t3", bus.pready_o,  1);
    chk("rd_prdata",    bus.prdata_o,  32'h0000_0712);
    chk("rd_slverr",    bus.pslverr_o, 0);
    chk("rd_done_cyc",  bus.wb_cyc_o,  0);
    apb_end();
    chk("rd_idle_pready", bus.pready_o, 0);
    chk("rd_pulses",  pulses - p0,  1);
    chk("rd_stb_cyc", stb_cyc - c0, 1);

    // Write with 3 stall cycles; an err during stall must be ignored.
    p0 = pulses; c0 = stb_cyc;
    apb_start(1'b1, 32'h0, 32'h0000_02F0, 4'b0011);
    chk("wr_we",  bus.wb_we_o,  1);
    chk("wr_sel", bus.wb_sel_o, 4'b0011);
    chk("wr_dat", bus.wb_dat_o, 32'h0000_02F0);
    chk("wr_adr", bus.wb_adr_o, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      bus.wb_stall_i = (k < 4);
      bus.wb_err_i   = (k == 2);
      chk("wr_stb_held", bus.wb_stb_o, 1);
      tick();
    end
    bus.wb_err_i = 1'b0;
    chk("wr_wait_stb", bus.wb_stb_o, 0);
    chk("wr_wait_cyc", bus.wb_cyc_o, 1);
    chk("wr_stb_cyc",  stb_cyc - c0, 4);
    chk("wr_pulses",   pulses - p0,  1);
    wb_resp(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    chk("wr_pready", bus.pready_o,  1);
    chk("wr_prdata", bus.prdata_o,  0);
    chk("wr_slverr", bus.pslverr_o, 0);
    apb_end();

    // Read ended by err in WAIT.
    apb_start(1'b0, 32'h20, 32'h0, 4'h0);
    tick();
    wb_resp(1'b0, 1'b1, 1'b0, 32'h0000_1234);
    chk("err_pready", bus.pready_o,  1);
    chk("err_slverr", bus.pslverr_o, 1);
    chk("err_prdata", bus.prdata_o,  0);
    apb_end();

    // Read ended by rty on the accepting strobe cycle, then abandoned.
    p0 = pulses;
    apb_start(1'b0, 32'h24, 32'h0, 4'h0);
    wb_resp(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("rty_pready", bus.pready_o,  1);
    chk("rty_slverr", bus.pslverr_o, 1);
    chk("rty_prdata", bus.prdata_o,  0);
    bus.psel_i = 1'b0; bus.penable_i = 1'b0;
    tick();
    chk("abandon_pready", bus.pready_o, 0);
    chk("abandon_cyc",    bus.wb_cyc_o, 0);
    chk("rty_pulses",     pulses - p0,  1);

    // err, rty and ack together: error wins.
    apb_start(1'b0, 32'h28, 32'h0, 4'h0);
    tick();
    wb_resp(1'b1, 1'b1, 1'b1, 32'h5555_AAAA);
    chk("multi_slverr", bus.pslverr_o, 1);
    chk("multi_prdata", bus.prdata_o,  0);
    apb_end();

    // Asynchronous reset while waiting for the slave.
    apb_start(1'b0, 32'h30, 32'h0, 4'h0);
    tick();
    chk("arst_pre_cyc", bus.wb_cyc_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cyc",    bus.wb_cyc_o, 0);
    chk("arst_stb",    bus.wb_stb_o, 0);
    chk("arst_pready", bus.pready_o, 0);
    bus.psel_i = 1'b0; bus.penable_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    apb_start(1'b0, 32'h34, 32'h0, 4'h0);
    tick();
    wb_resp(1'b1, 1'b0, 1'b0, 32'hA5A5_0001);
    chk("post_rst_pready", bus.pready_o,  1);
    chk("post_rst_prdata", bus.prdata_o,  32'hA5A5_0001);
    chk("post_rst_slverr", bus.pslverr_o, 0);
    apb_end();

    // Back-to-back reads with psel held across the boundary.
    p0 = pulses;
    apb_start(1'b0, 32'h4, 32'h0, 4'h0);
    wb_resp(1'b1, 1'b0, 1'b0, 32'h1111_1111);
    chk("b2b1_pready", bus.pready_o, 1);
    chk("b2b1_prdata", bus.prdata_o, 32'h1111_1111);
    tick();
    chk("b2b_gap_cyc",    bus.wb_cyc_o, 0);
    chk("b2b_gap_pready", bus.pready_o, 0);
    bus.penable_i = 1'b0;
    bus.paddr_i   = 32'h8;
    tick();
    bus.penable_i = 1'b1;
    chk("b2b2_cyc", bus.wb_cyc_o, 1);
    chk("b2b2_adr", bus.wb_adr_o, 32'h8);
    tick();
    wb_resp(1'b1, 1'b0, 1'b0, 32'h2222_2222);
    chk("b2b2_pready", bus.pready_o, 1);
    chk("b2b2_prdata", bus.prdata_o, 32'h2222_2222);
    apb_end();
    chk("b2b_pulses", pulses - p0, 2);

    // Watchdog with TIMEOUT=8 and a silent slave.
    bus8.psel_i = 1'b1; bus8.penable_i = 1'b0; bus8.pwrite_i = 1'b0; bus8.paddr_i = 32'h40;
    tick();
    bus8.penable_i = 1'b1;
    n = 0;
    for (int i = 0; i < 12 && !bus8.pready_o; i++) begin
      if (bus8.wb_cyc_o) n++;
      tick();
    end
    chk("to8_cyc_cycles", n, 8);
    chk("to8_pready", bus8.pready_o,  1);
    chk("to8_slverr", bus8.pslverr_o, 1);
    chk("to8_prdata", bus8.prdata_o,  0);
    chk("to8_cyc",    bus8.wb_cyc_o,  0);
    tick();
    bus8.psel_i = 1'b0; bus8.penable_i = 1'b0;
    chk("to8_idle_pready", bus8.pready_o, 0);

    // Watchdog disabled: the cycle must stay open.
    bus0.psel_i = 1'b1; bus0.penable_i = 1'b0; bus0.pwrite_i = 1'b0; bus0.paddr_i = 32'h44;
    tick();
    bus0.penable_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus0.pready_o || !bus0.wb_cyc_o) bad++;
      tick();
    end
    chk("to0_no_termination", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/apb2wb_bridge.md
Name: apb2wb_bridge

Overview:
Upstream bus bridge that feeds the generated Wishbone register banks (pipelined Wishbone slaves with a 32-bit data bus, such as the reg0 control bank). It accepts single APB3/APB4 transfers from the host interconnect and issues exactly one pipelined Wishbone classic-cycle per transfer. It returns read data and status to APB. A timeout watchdog prevents a non-responding slave from hanging the host.

Parameters:
ADDR_WIDTH, 32, byte-address width on both buses; passed through unchanged.
TIMEOUT, 255, max cycles from first wb_stb_o to termination; 0 disables the watchdog.

Ports:
clk_i  in  1  single clock for both buses
rst_n_i  in  1  reset, asynchronous, active-low
psel_i  in  1  APB select
penable_i  in  1  APB access phase
pwrite_i  in  1  APB direction, 1 = write
paddr_i  in  ADDR_WIDTH  APB byte address
pwdata_i  in  32  APB write data
pstrb_i  in  4  APB byte strobes
pready_o  out  1  APB transfer complete
prdata_o  out  32  APB read data
pslverr_o  out  1  APB error
wb_cyc_o  out  1  WB cycle
wb_stb_o  out  1  WB strobe
wb_we_o  out  1  WB write enable
wb_adr_o  out  ADDR_WIDTH  WB byte address
wb_sel_o  out  4  WB byte select
wb_dat_o  out  32  WB write data
wb_ack_i  in  1  WB acknowledge
wb_err_i  in  1  WB error
wb_rty_i  in  1  WB retry
wb_stall_i  in  1  WB pipelined stall
wb_dat_i  in  32  WB read data

Behaviour:
- Reset is asynchronous, active-low. While low: state IDLE, all outputs 0, capture registers 0, timeout counter 0.
- All outputs are registered or decoded directly from state. There is no combinational path from APB inputs to WB outputs.
- FSM states:
  - IDLE:
    - psel_i=1 → latch paddr_i, pwdata_i, pwrite_i.
    - Latch sel = pwrite_i ? pstrb_i : 4'hF.
    - Clear the counter and go to STB.
  - STB:
    - wb_cyc_o=1, wb_stb_o=1; address, data, we and sel come from the latches.
    - wb_stall_i=1: remain in STB. Any ack/err/rty seen while stalled is ignored as a protocol violation.
    - wb_stall_i=0 with no termination → WAIT.
    - wb_stall_i=0 with a termination in the same cycle → DONE.
  - WAIT:
    - wb_cyc_o=1, wb_stb_o=0.
    - The first of ack/err/rty → DONE.
    - Priority when several are asserted: err > rty > ack.
  - DONE:
    - wb_cyc_o=0, pready_o=1, prdata_o and pslverr_o hold the captured response.
    - psel_i=1 and penable_i=1 → the APB transfer completes this cycle; go to IDLE.
    - psel_i=0 → transfer abandoned; response discarded; go to IDLE.
- Response capture:
  - ack on a read: prdata = wb_dat_i, slverr = 0.
  - ack on a write: prdata = 0, slverr = 0.
  - err, rty or timeout: prdata = 0, slverr = 1.
- Timeout:
  - The counter increments every cycle in STB and WAIT and saturates.
  - When TIMEOUT != 0 and the counter reaches TIMEOUT-1 without termination: next state is DONE with slverr=1, and cyc/stb drop.
  - A termination arriving in the same cycle as the timeout wins.
  - Counter width is clog2(TIMEOUT+1), minimum 1.
- Latency (best case, zero stall, slave acks one cycle after accepting the strobe):
  - APB setup in cycle T0.
  - stb in T1, ack in T2.
  - pready_o in T3.
- Exactly one WB strobe is issued per APB transfer. psel_i held beyond DONE does not re-trigger until the state returns to IDLE; the next transfer is then recognised in IDLE.
- pready_o=0 in all states other than DONE.
- An APB4 pprot input is not used.

Decomposition:
- Package apb2wb_pkg:
  - state enum {IDLE, STB, WAIT, DONE};
  - DATA_WIDTH=32 and SEL_WIDTH=4 constants;
  - function computing the counter width from TIMEOUT.
- No sub-module. The watchdog is a saturating counter inline in the bridge.

Test Plan:
- Read with zero stall, ack one cycle after stb, wb_dat_i=0x00000712 → exactly one stb pulse with we=0 and sel=F; pready_o=1 in T3 with prdata_o=0x00000712 and pslverr_o=0.
- Write paddr=0x0, pwdata=0x000002F0, pstrb=4'b0011, wb_stall_i high for 3 cycles → stb held 4 cycles then single acceptance; wb_sel_o=4'b0011; pslverr_o=0 and prdata_o=0.
- Read terminated by wb_err_i → pslverr_o=1 and prdata_o=0. Repeat with wb_rty_i → same result. err and rty together → pslverr_o=1.
- TIMEOUT=8 with the slave silent → cyc drops after exactly 8 STB/WAIT cycles, then pready_o=1 with pslverr_o=1. TIMEOUT=0 → no termination within 1000 cycles.
- rst_n_i asserted asynchronously while in WAIT → wb_cyc_o, wb_stb_o and pready_o go to 0 immediately without a clock edge. After release the next read completes normally.
- Two back-to-back APB reads with psel_i held → two separate WB cycles, with wb_cyc_o low for at least one cycle between them; each pready_o carries its own data.
